// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
package seq_addsub_pkg;

  // Controller states: accept operands, walk the chunks, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 with a floor of one bit, so a single-chunk build still has an index register.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result bus for seq_addsub.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
// The producer holds its payload stable while valid is high; ready never depends
// combinationally on valid, and the consumer must sample the payload only while valid is high.
interface seq_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  // Environment side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  // Arithmetic block side.
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Combinational CHUNK-bit ripple adder. Also exposes the carry into the MSB so the
// caller can form signed overflow as (carry into MSB) xor (carry out of MSB).
module seq_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_msb_ci
);

  // Bit-serial ripple of the carry through the chunk.
  always_comb begin
    logic [CHUNK:0] v_c;
    v_c      = '0;
    o_s      = '0;
    v_c[0]   = i_ci;
    for (int i = 0; i < CHUNK; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ v_c[i];
      v_c[i+1] = (i_a[i] & i_b[i]) | (i_a[i] & v_c[i]) | (i_b[i] & v_c[i]);
    end
    o_co     = v_c[CHUNK];
    o_msb_ci = v_c[CHUNK-1];
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock.
// Subtraction is a + ~b + ~ci, so the operand and carry are inverted once on accept
// and the datapath only ever adds. Result, carry-out and overflow are held in DONE
// until the consumer takes them.
import seq_addsub_pkg::*;

module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus,
  output state_t       o_dbg_state
);

  localparam int              NCHUNK   = WIDTH / CHUNK;
  localparam int              IDXW     = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_co;
  logic             r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_msb_ci;

  assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_chunk = r_bx[r_idx*CHUNK +: CHUNK];

  seq_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a      (w_a_chunk),
    .i_b      (w_b_chunk),
    .i_ci     (r_carry),
    .o_s      (w_sum),
    .o_co     (w_cout),
    .o_msb_ci (w_msb_ci)
  );

  // Controller, chunk walker and result registers; handshake outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_bx        <= '0;
      r_s         <= '0;
      r_carry     <= 1'b0;
      r_co        <= 1'b0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_bx       <= bus.b ^ {WIDTH{bus.sub}};
            r_carry    <= bus.ci ^ bus.sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s[r_idx*CHUNK +: CHUNK] <= w_sum;
          r_carry                   <= w_cout;
          if (r_idx == LAST_IDX) begin
            // Last chunk holds the MSB: its carries give co and signed overflow.
            r_co        <= w_cout;
            r_ovf       <= w_cout ^ w_msb_ci;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.co        = r_co;
  assign bus.ovf       = r_ovf;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: a 4-chunk instance and a single-chunk instance share one
// stimulus source, each with its own in_valid.
module tb_seq_addsub;
  import seq_addsub_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  seq_addsub_if #(.WIDTH(W)) bus0 ();
  seq_addsub_if #(.WIDTH(W)) bus1 ();
  state_t dbg0;
  state_t dbg1;

  logic [W-1:0] t_a;
  logic [W-1:0] t_b;
  logic         t_ci;
  logic         t_sub;
  logic         t_out_ready;
  logic         t_iv0;
  logic         t_iv1;

  assign bus0.in_valid  = t_iv0;
  assign bus0.a         = t_a;
  assign bus0.b         = t_b;
  assign bus0.ci        = t_ci;
  assign bus0.sub       = t_sub;
  assign bus0.out_ready = t_out_ready;
  assign bus1.in_valid  = t_iv1;
  assign bus1.a         = t_a;
  assign bus1.b         = t_b;
  assign bus1.ci        = t_ci;
  assign bus1.sub       = t_sub;
  assign bus1.out_ready = t_out_ready;

  seq_addsub #(.WIDTH(W), .CHUNK(8)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus0),
    .o_dbg_state (dbg0)
  );

  seq_addsub #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1),
    .o_dbg_state (dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];   // {ovf, co, s}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact arithmetic on the operands, then read off result bits, carry and range.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sub);
    logic [W:0] t;
    longint     sv;
    logic       co;
    logic       ovf;
    if (!sub) begin
      t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      co = t[W];
      sv = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    end else begin
      t  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      co = ~t[W];                 // 1 means no borrow
      sv = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
    end
    ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {ovf, co, t[W-1:0]};
  endfunction

  function automatic logic obs_ir(input bit sel);
    return sel ? bus1.in_ready : bus0.in_ready;
  endfunction
  function automatic logic obs_ov(input bit sel);
    return sel ? bus1.out_valid : bus0.out_valid;
  endfunction
  function automatic logic [W+1:0] obs_res(input bit sel);
    return sel ? {bus1.ovf, bus1.co, bus1.s} : {bus0.ovf, bus0.co, bus0.s};
  endfunction
  function automatic state_t obs_st(input bit sel);
    return sel ? dbg1 : dbg0;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one operation and follows it to completion. stall = cycles out_ready is
  // held low in DONE while in_valid is pulsed with unrelated operands.
  task automatic run_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub, input int stall, input string tag);
    int           lat;
    int           extra;
    logic [W+1:0] exp;
    logic [W+1:0] got;
    check({tag, "_in_ready"}, 64'(obs_ir(sel)), 64'(1));
    t_a = a; t_b = b; t_ci = ci; t_sub = sub;
    t_out_ready = (stall == 0);
    if (sel) t_iv1 = 1'b1; else t_iv0 = 1'b1;
    exp_q.push_back(model(a, b, ci, sub));
    @(posedge clk); #1;
    t_iv0 = 1'b0; t_iv1 = 1'b0;
    t_a = $urandom; t_b = $urandom; t_ci = 1'($urandom); t_sub = 1'($urandom);
    lat = 0;
    while (!obs_ov(sel) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), sel ? 64'(1) : 64'(4));
    exp = exp_q.pop_front();
    got = obs_res(sel);
    check({tag, "_s"},   64'(got[W-1:0]), 64'(exp[W-1:0]));
    check({tag, "_co"},  64'(got[W]),     64'(exp[W]));
    check({tag, "_ovf"}, 64'(got[W+1]),   64'(exp[W+1]));
    check({tag, "_dbg_done"}, 64'(obs_st(sel)), 64'(ST_DONE));
    for (int i = 0; i < stall; i++) begin
      t_a = $urandom; t_b = $urandom;
      if (sel) t_iv1 = 1'b1; else t_iv0 = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(obs_ov(sel)), 64'(1));
      check({tag, "_hold_in_ready"}, 64'(obs_ir(sel)), 64'(0));
      check({tag, "_hold_result"}, 64'(obs_res(sel)), 64'(exp));
    end
    t_iv0 = 1'b0; t_iv1 = 1'b0;
    t_out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_release_valid"}, 64'(obs_ov(sel)), 64'(0));
    check({tag, "_release_in_ready"}, 64'(obs_ir(sel)), 64'(1));
    if (stall > 0) begin
      // Operands offered during DONE must not have been queued.
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (obs_ov(sel)) extra++;
      end
      check({tag, "_no_queued_op"}, 64'(extra), 64'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int spurious;
    rst = 1'b1;
    t_a = '0; t_b = '0; t_ci = 1'b0; t_sub = 1'b0;
    t_out_ready = 1'b1; t_iv0 = 1'b0; t_iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus0.in_ready),  64'(1));
    check("rst_out_valid", 64'(bus0.out_valid), 64'(0));
    check("rst_s",         64'(bus0.s),         64'(0));
    check("rst_co",        64'(bus0.co),        64'(0));
    check("rst_ovf",       64'(bus0.ovf),       64'(0));
    check("rst_dbg",       64'(dbg0),           64'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with the 4-chunk instance.
    run_op(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, "add_1_1");
    check("add_1_1_value", 64'(exp_q.size()), 64'(0));
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, "add_ripple");
    run_op(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, "sub_5_7");
    run_op(1'b0, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, "sub_7_5_b");
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_ovf");
    run_op(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, "sub_ovf");

    // Backpressure: result held three cycles while a second op is offered.
    run_op(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 3, "backpressure");

    // Reset on the second RUN edge discards the operation.
    t_a = 32'hDEAD_BEEF; t_b = 32'h0000_1111; t_ci = 1'b0; t_sub = 1'b0;
    t_iv0 = 1'b1;
    @(posedge clk); #1;          // accept edge
    t_iv0 = 1'b0;
    @(posedge clk); #1;          // first RUN edge
    rst = 1'b1;
    @(posedge clk); #1;          // second RUN edge, reset wins
    rst = 1'b0;
    check("midrun_rst_in_ready",  64'(bus0.in_ready),  64'(1));
    check("midrun_rst_out_valid", 64'(bus0.out_valid), 64'(0));
    check("midrun_rst_s",         64'(bus0.s),         64'(0));
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) spurious++;
    end
    check("midrun_rst_no_result", 64'(spurious), 64'(0));
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, "after_rst");

    // Randomised operations, with occasional backpressure.
    for (int n = 0; n < 30; n++) begin
      run_op(1'b0, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), "rand4");
    end

    // Single-chunk build: one RUN edge, same arithmetic.
    run_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "n1_add_ovf");
    run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1, "n1_sub");
    for (int n = 0; n < 10; n++) begin
      run_op(1'b1, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 1)), "rand1");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: observed no completion expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation time limit");
  end

endmodule
